// File: rtl/fp_norm_round.sv
// Normalize-and-round stage of the FP add/sub datapath: iterative one-bit normalization, RNE rounding, IEEE single packing.
// Optional build macro FP_NORM_FTZ_EN flushes subnormal results to signed zero.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+1:0]       in_mant,
    input  logic [2:0]              in_grs,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact,
    output logic                    busy
);

    localparam int MW  = FRAC_W + 2;
    localparam int IEW = EXP_W + 1;
    localparam logic [IEW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [IEW-1:0] EXP_ONE = IEW'(1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and the result stay constant until that transfer occurs.
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q;
    logic [IEW-1:0]  exp_q;
    logic [MW-1:0]   mant_q;
    logic            g_q, r_q, s_q;
    logic            tiny_q;
    logic            inf_q;

    logic                  is_zero;
    logic                  inc;
    logic [MW-1:0]         sum;
    logic [MW-1:0]         rmant;
    logic [IEW-1:0]        rexp;
    logic [IEW-1:0]        field;
    logic [EXP_W+FRAC_W:0] res_d;
    logic                  ovf_d, unf_d, inx_d;

    assign is_zero  = (mant_q == '0) && !g_q && !r_q && !s_q;
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Zero and infinity pass through ROUND so every non-shifting case has the same latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = NORM;
            NORM: begin
                if (is_zero || inf_q || mant_q[MW-1] || mant_q[FRAC_W] || exp_q <= EXP_ONE)
                    state_d = ROUND;
            end
            ROUND: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inc   = g_q & (r_q | s_q | mant_q[0]);
        sum   = mant_q + MW'(inc);
        rmant = sum;
        rexp  = exp_q;
        if (sum[MW-1]) begin
            rmant = sum >> 1;
            rexp  = exp_q + EXP_ONE;
        end
        // Exponents 0 and 1 share the subnormal scale, so a round-up into the hidden bit lands on field 1.
        field = '0;
        if (rmant[FRAC_W]) field = (rexp == '0) ? EXP_ONE : rexp;
        inx_d = g_q | r_q | s_q;
        ovf_d = 1'b0;
        res_d = {sign_q, field[EXP_W-1:0], rmant[FRAC_W-1:0]};
        if (rexp >= EXP_MAX) begin
            res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end
        unf_d = tiny_q & inx_d;
`ifdef FP_NORM_FTZ_EN
        if (field == '0 && rmant[FRAC_W-1:0] != '0) begin
            res_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
`endif
        if (is_zero) begin
            res_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inx_d = 1'b0;
        end else if (inf_q) begin
            res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
            unf_d = 1'b0;
            inx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            g_q    <= 1'b0;
            r_q    <= 1'b0;
            s_q    <= 1'b0;
            tiny_q <= 1'b0;
            inf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= {1'b0, in_exp};
                        mant_q <= in_mant;
                        g_q    <= in_grs[2];
                        r_q    <= in_grs[1];
                        s_q    <= in_grs[0];
                        tiny_q <= 1'b0;
                        inf_q  <= &in_exp;
                    end
                end
                NORM: begin
                    if (!is_zero && !inf_q) begin
                        if (mant_q[MW-1]) begin
                            mant_q <= mant_q >> 1;
                            g_q    <= mant_q[0];
                            r_q    <= g_q;
                            s_q    <= r_q | s_q;
                            exp_q  <= exp_q + EXP_ONE;
                        end else if (!mant_q[FRAC_W] && exp_q > EXP_ONE) begin
                            mant_q <= {mant_q[MW-2:0], g_q};
                            g_q    <= r_q;
                            r_q    <= 1'b0;
                            exp_q  <= exp_q - EXP_ONE;
                        end else if (!mant_q[FRAC_W]) begin
                            tiny_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (state_q == ROUND) begin
            out_valid     <= 1'b1;
            out_result    <= res_d;
            out_overflow  <= ovf_d;
            out_underflow <= unf_d;
            out_inexact   <= inx_d;
        end else if (state_q == DONE && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: hand-computed vectors, latency, backpressure and mid-operation reset.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic [2:0]  in_grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_inexact(out_inexact),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one transaction, measure latency, optionally stall the output, then accept it.
    task automatic run_txn(input string tag, input logic sign, input logic [7:0] e, input logic [24:0] m,
                           input logic [2:0] grs, input logic [31:0] exp_res, input logic exp_ovf,
                           input logic exp_unf, input logic exp_inx, input int exp_lat, input int hold);
        int lat;
        logic [31:0] held;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_sign  = sign;
        in_exp   = e;
        in_mant  = m;
        in_grs   = grs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, out_result, exp_res);
        check({tag, " flags ovf/unf/inx"}, {29'b0, out_overflow, out_underflow, out_inexact},
              {29'b0, exp_ovf, exp_unf, exp_inx});
        held = out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, out_result, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " accepted"}, 32'(out_valid), 32'd0);
        check({tag, " back idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, " no repeat"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'h0);
        check("reset flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset in_ready", 32'(in_ready), 32'd1);

        run_txn("norm 1.5", 1'b0, 8'h7F, 25'h0C00000, 3'b000, 32'h3FC00000, 0, 0, 0, 2, 0);
        run_txn("carry 3.0", 1'b0, 8'h7F, 25'h1800000, 3'b000, 32'h40400000, 0, 0, 0, 2, 0);
        run_txn("ovf round", 1'b0, 8'hFE, 25'h1FFFFFF, 3'b000, 32'h7F800000, 1, 0, 1, 2, 0);
        run_txn("left2 stall", 1'b0, 8'h80, 25'h0200000, 3'b000, 32'h3F000000, 0, 0, 0, 4, 5);
        run_txn("rne tie odd", 1'b0, 8'h7F, 25'h0800001, 3'b100, 32'h3F800002, 0, 0, 1, 2, 0);
        run_txn("rne tie even", 1'b0, 8'h7F, 25'h0800000, 3'b100, 32'h3F800000, 0, 0, 1, 2, 0);
        run_txn("rne above", 1'b0, 8'h7F, 25'h0800000, 3'b101, 32'h3F800001, 0, 0, 1, 2, 0);
        run_txn("neg zero", 1'b1, 8'h40, 25'h0000000, 3'b000, 32'h80000000, 0, 0, 0, 2, 0);
        run_txn("neg inf in", 1'b1, 8'hFF, 25'h0800000, 3'b000, 32'hFF800000, 1, 0, 0, 2, 0);
`ifdef FP_NORM_FTZ_EN
        run_txn("subn exact", 1'b0, 8'h01, 25'h0400000, 3'b000, 32'h00000000, 0, 1, 1, 2, 0);
        run_txn("subn inexact", 1'b0, 8'h01, 25'h0400000, 3'b010, 32'h00000000, 0, 1, 1, 2, 0);
`else
        run_txn("subn exact", 1'b0, 8'h01, 25'h0400000, 3'b000, 32'h00400000, 0, 0, 0, 2, 0);
        run_txn("subn inexact", 1'b0, 8'h01, 25'h0400000, 3'b010, 32'h00400000, 0, 1, 1, 2, 0);
`endif
        // 0x90 - 23 shifts = 0x79
        run_txn("left23", 1'b0, 8'h90, 25'h0000001, 3'b000, 32'h3C800000, 0, 0, 0, 25, 0);

        in_sign  = 1'b0;
        in_exp   = 8'h90;
        in_mant  = 25'h0000001;
        in_grs   = 3'b000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #3;
        check("abort busy in reset", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("abort no output", 32'(seen), 32'd0);
        run_txn("after abort", 1'b0, 8'h7F, 25'h0C00000, 3'b000, 32'h3FC00000, 0, 0, 0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
